// File: rtl/sqrt_pkg.sv
// sqrt_pkg: shared FSM state type for the square-root engine
package sqrt_pkg;
    typedef enum logic [1:0] {LOAD, CALC, DONE} state_t;
endpackage

// File: rtl/sqrt_iter_step.sv
// sqrt_iter_step: one restoring digit-recurrence step producing a single root bit
module sqrt_iter_step #(
    parameter int Size = 64
) (
    input  logic [Size/2+1:0] i_rem,
    input  logic [Size/2-1:0] i_root,
    input  logic [1:0]        i_bits,
    output logic [Size/2+1:0] o_rem,
    output logic [Size/2-1:0] o_root
);
    logic [Size/2+1:0] w_shift;
    logic [Size/2+1:0] w_trial;
    logic              w_ge;
    // bits shifted out of the remainder can only make rem' larger, so they force a 1 digit
    always_comb begin
        w_shift = {i_rem[Size/2-1:0], i_bits};
        w_trial = {i_root, 2'b01};
        w_ge    = (i_rem[Size/2+1:Size/2] != 2'b00) || (w_shift >= w_trial);
        o_rem   = w_ge ? w_shift - w_trial : w_shift;
        o_root  = {i_root[Size/2-2:0], w_ge};
    end
endmodule

// File: rtl/sqrt.sv
// sqrt: sequential integer floor square root, one root bit per cycle, restarted by reset
module sqrt
    import sqrt_pkg::*;
#(
    parameter int Size = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [Size-1:0]     operand,
    output logic                done,
    output logic [Size/2-1:0]   result
);
    localparam int H  = Size / 2;
    localparam int CW = $clog2(H + 1);

    state_t          r_state;
    logic [Size-1:0] r_rad;
    logic [H+1:0]    r_rem;
    logic [H-1:0]    r_root;
    logic [H-1:0]    r_result;
    logic [CW-1:0]   r_cnt;
    logic            r_done;
    logic [H+1:0]    w_rem;
    logic [H-1:0]    w_root;

    sqrt_iter_step #(.Size(Size)) u_step (
        .i_rem  (r_rem),
        .i_root (r_root),
        .i_bits (r_rad[Size-1:Size-2]),
        .o_rem  (w_rem),
        .o_root (w_root)
    );

    assign done   = r_done;
    assign result = r_result;

    // capture operand, iterate H times MSB first, then publish the root and hold it
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= LOAD;
            r_rad    <= '0;
            r_rem    <= '0;
            r_root   <= '0;
            r_cnt    <= '0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            case (r_state)
                LOAD: begin
                    r_rad   <= operand;
                    r_rem   <= '0;
                    r_root  <= '0;
                    r_cnt   <= CW'(H);
                    r_state <= CALC;
                end
                CALC: begin
                    r_rad  <= {r_rad[Size-3:0], 2'b00};
                    r_rem  <= w_rem;
                    r_root <= w_root;
                    r_cnt  <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_state  <= DONE;
                        r_done   <= 1'b1;
                        r_result <= w_root;
                    end
                end
                DONE: r_state <= DONE;
                default: r_state <= LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_sqrt.sv
// tb_sqrt: randomized and directed checks of sqrt against a binary-search square-root model
module tb_sqrt;
    logic        clk;
    logic        reset;
    logic [63:0] operand;
    logic        done;
    logic [31:0] result;

    int total = 0;
    int bad   = 0;

    int          m_cnt   = 0;
    logic        m_valid = 1'b0;
    logic [63:0] m_op    = '0;

    sqrt #(.Size(64)) dut (
        .clk     (clk),
        .reset   (reset),
        .operand (operand),
        .done    (done),
        .result  (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] isqrt(input logic [63:0] v);
        logic [127:0] lo, hi, mid;
        lo = 128'd0;
        hi = 128'd1 << 32;
        while (hi - lo > 128'd1) begin
            mid = (lo + hi) >> 1;
            if (mid * mid <= {64'd0, v}) lo = mid;
            else hi = mid;
        end
        return lo[31:0];
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // model: edges since reset release and the operand seen on the first of them
    always @(posedge clk) begin
        if (reset) begin
            m_cnt   = 0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            if (m_cnt == 0) m_op = operand;
            if (m_cnt < 100) m_cnt++;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("cyc_done", {127'd0, done}, {127'd0, m_cnt >= 33});
            chk("cyc_result", {96'd0, result}, m_cnt >= 33 ? {96'd0, isqrt(m_op)} : 128'd0);
        end
    end

    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!done) chk("timeout", 128'd0, 128'd1);
    endtask

    task automatic run(input logic [63:0] op, output logic [31:0] r, output int lat);
        reset   = 1'b1;
        operand = {$urandom, $urandom};
        @(negedge clk);
        reset   = 1'b0;
        operand = op;
        wait_done(lat);
        r = result;
    endtask

    logic [63:0] ops  [7] = '{64'd0, 64'd1, 64'd15, 64'd16,
                              64'hFFFFFFFE00000001, 64'hFFFFFFFE00000000, 64'hFFFFFFFFFFFFFFFF};
    logic [31:0] exps [7] = '{32'd0, 32'd1, 32'd3, 32'd4,
                              32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFF};

    initial begin
        logic [31:0]  r, cap, k;
        logic [63:0]  op;
        logic [127:0] rr;
        int           lat;
        reset   = 1'b1;
        operand = '0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_done", {127'd0, done}, 128'd0);
        chk("reset_result", {96'd0, result}, 128'd0);
        for (int i = 0; i < 7; i++) begin
            chk("model_pin", {96'd0, isqrt(ops[i])}, {96'd0, exps[i]});
            run(ops[i], r, lat);
            chk("directed", {96'd0, r}, {96'd0, exps[i]});
            chk("latency", lat, 33);
        end
        cap = result;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stable", {96'd0, result}, {96'd0, cap});
        end
        reset = 1'b1;
        @(negedge clk);
        reset   = 1'b0;
        operand = 64'd1000000;
        repeat (10) @(negedge clk);
        operand = 64'd0;
        wait_done(lat);
        chk("mid_operand_change", {96'd0, result}, 128'd1000);
        reset = 1'b1;
        @(negedge clk);
        reset   = 1'b0;
        operand = 64'hFFFFFFFFFFFFFFFF;
        repeat (12) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_reset_done", {127'd0, done}, 128'd0);
        chk("mid_reset_result", {96'd0, result}, 128'd0);
        reset   = 1'b0;
        operand = 64'd144;
        wait_done(lat);
        chk("after_abort", {96'd0, result}, 128'd12);
        chk("after_abort_latency", lat, 33);
        for (int i = 0; i < 1000; i++) begin
            k = $urandom;
            case (i % 4)
                0: op = {$urandom, $urandom};
                1: op = {32'd0, k} * {32'd0, k};
                2: op = {32'd0, k} * {32'd0, k} - 64'd1;
                default: op = {$urandom, $urandom} >> $urandom_range(63, 0);
            endcase
            run(op, r, lat);
            rr = {96'd0, r};
            chk("rand_bounds", {127'd0, (rr * rr <= {64'd0, op}) && ({64'd0, op} < (rr + 1) * (rr + 1))}, 128'd1);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sqrt.md
SQRT -- requirements
Module: sqrt

Interface
REQ-001 Parameter Size, default 64, operand width in bits; SHALL be even and >= 4; result width is Size/2.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset; also the start command for a new computation.
REQ-004 operand  input  Size  unsigned radicand.
REQ-005 done  output  1  high when result is valid.
REQ-006 result  output  Size/2  floor(sqrt(operand)), unsigned.

Function
REQ-007 result SHALL be the exact integer floor square root of operand for every value in 0..2^Size-1, computed with integer arithmetic only (no floating point).
REQ-008 States SHALL be LOAD, CALC and DONE; reset forces LOAD.
REQ-009 LOAD: on the first rising edge with reset low, operand SHALL be captured into an internal radicand register, the remainder and root registers cleared, the iteration counter set to Size/2, and the state moved to CALC.
REQ-010 CALC: each cycle SHALL produce one root bit, MSB first, using restoring digit recurrence: rem' = {rem, next 2 radicand bits}; trial = {root, 2'b01}; if rem' >= trial then rem = rem' - trial and root = {root, 1}, else rem = rem' and root = {root, 0}.
REQ-011 The remainder register SHALL be Size/2+2 bits wide so that no overflow occurs.
REQ-012 After Size/2 CALC cycles the state SHALL move to DONE.
REQ-013 done SHALL rise exactly Size/2+1 rising edges after the first edge with reset low (33 edges for Size=64). It SHALL then stay high with result stable until the next reset.
REQ-014 operand changes after the LOAD edge SHALL be ignored. The value sampled at the LOAD edge defines the result.
REQ-015 While done is low, result SHALL be 0 and SHALL NOT expose partial roots.
REQ-016 There SHALL be no other start or abort input. Asserting reset in any state, including mid-CALC, SHALL abandon the computation.

Reset
REQ-017 On a rising edge with reset high: state = LOAD, done = 0, result = 0, and all internal registers cleared.
REQ-018 Reset held for multiple cycles SHALL keep these values. Computation SHALL begin only on the first edge with reset low.

Structure
REQ-019 A shared package SHALL hold the state enum type (LOAD, CALC, DONE).
REQ-020 One combinational sub-module, sqrt_iter_step, SHALL implement a single recurrence step: inputs rem, root and 2 radicand bits; outputs new rem and new root. It is parameterized by Size.
REQ-021 The top level SHALL contain only the FSM, the counter, the shift registers and the output register.

Verification
REQ-022 For each case: reset one cycle, then apply operand, then wait for done. Checks at Size=64:
- operand 0 -> result 0
- operand 1 -> result 1
- operand 15 -> result 3
- operand 16 -> result 4
REQ-023 operand 0xFFFFFFFE00000001 -> 0xFFFFFFFF. operand 0xFFFFFFFE00000000 -> 0xFFFFFFFE. operand 0xFFFFFFFFFFFFFFFF -> 0xFFFFFFFF.
REQ-024 Latency check: done low for exactly the first 32 edges after reset deassertion and high on edge 33. result stays stable for at least 10 further cycles.
REQ-025 Change operand mid-CALC -> result still matches the value captured at the LOAD edge. Assert reset mid-CALC -> done and result return to 0, and the new operand is computed correctly.
REQ-026 1000 random 64-bit operands each SHALL satisfy r*r <= operand < (r+1)*(r+1), computed in 128-bit integer arithmetic. The bench SHALL count errors and report the total at the end.
